// File: rtl/gate_pulse_monitor.sv
// rtl/gate_pulse_monitor.sv - receive-side rise/fall/width checker for one gate bit per laser period
//
// Samples gate_data_in[bit_sel] against the shared laser period counter and
// reports, for each full period, the first rise, the first fall after it,
// the pulse width and error flags through a single-entry valid/ready result.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   laser_cnt_in, laser_freq laser period counter and its terminal value
//   gate_data_in             gate bus under test
//   bit_sel, meas_cycles     bit to watch and period count (0 = run until stop), latched on start
//   start, stop              arm / abort pulses
//   busy, done               run in progress, one-cycle completion pulse
//   result_*                 per-period result, held until result_ready
//   overflow                 sticky: a result was dropped while one was pending
module gate_pulse_monitor #(
    parameter int CNT_WIDTH = 32,
    parameter int GATE_BITS = 10,
    parameter int SEL_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] laser_cnt_in,
    input  logic [CNT_WIDTH-1:0] laser_freq,
    input  logic [GATE_BITS-1:0] gate_data_in,
    input  logic [SEL_WIDTH-1:0] bit_sel,
    input  logic [7:0]           meas_cycles,
    input  logic                 start,
    input  logic                 stop,
    output logic                 busy,
    output logic                 done,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [CNT_WIDTH-1:0] result_rise,
    output logic [CNT_WIDTH-1:0] result_fall,
    output logic [CNT_WIDTH-1:0] result_width,
    output logic [2:0]           result_flags,
    output logic [7:0]           result_idx,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEAS,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [SEL_WIDTH-1:0]      sel_q;
    logic [7:0]                meas_n;
    logic [7:0]                idx;
    logic [(1<<SEL_WIDTH)-1:0] gate_ext;
    logic                      g, g_q, rise_e, fall_e, hit, period_end;

    // Per-period capture state
    logic                 have_rise, have_fall, multi;
    logic [CNT_WIDTH-1:0] rise_ts, fall_ts;

    // Capture state including an edge seen on the current cycle
    logic                 c_have_rise, c_have_fall, c_multi;
    logic [CNT_WIDTH-1:0] c_rise_ts, c_fall_ts;

    // Zero-extend the bus so an out-of-range bit_sel reads a constant low.
    always_comb begin
        gate_ext                = '0;
        gate_ext[GATE_BITS-1:0] = gate_data_in;
    end

    assign g      = gate_ext[sel_q];
    assign rise_e = g & ~g_q;
    assign fall_e = ~g & g_q;
    assign hit    = (laser_cnt_in >= laser_freq);

    // The hit-cycle sample still belongs to the ending period, so the result
    // is built from the capture state merged with this cycle's edge.
    assign c_have_rise = have_rise | rise_e;
    assign c_rise_ts   = have_rise ? rise_ts : laser_cnt_in;
    assign c_multi     = multi | (rise_e & have_rise);
    assign c_have_fall = have_fall | (fall_e & have_rise);
    assign c_fall_ts   = have_fall ? fall_ts : laser_cnt_in;

    // stop wins over a coincident boundary: an aborted run reports nothing.
    assign period_end = (state == S_MEAS) && hit && !stop;

    assign busy = (state == S_ARM) || (state == S_MEAS);
    assign done = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_ARM;
            S_ARM: begin
                if (stop)     state_nx = S_IDLE;
                else if (hit) state_nx = S_MEAS;
            end
            S_MEAS: begin
                if (stop) state_nx = S_IDLE;
                else if (hit && (meas_n != 8'd0) && ((idx + 8'd1) == meas_n))
                    state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            sel_q        <= '0;
            meas_n       <= '0;
            idx          <= '0;
            g_q          <= 1'b0;
            have_rise    <= 1'b0;
            have_fall    <= 1'b0;
            multi        <= 1'b0;
            rise_ts      <= '0;
            fall_ts      <= '0;
            result_valid <= 1'b0;
            result_rise  <= '0;
            result_fall  <= '0;
            result_width <= '0;
            result_flags <= '0;
            result_idx   <= '0;
            overflow     <= 1'b0;
        end else begin
            state <= state_nx;
            // g_q is not cleared at boundaries: a gate held high across one
            // must not look like a fresh rise in the new period.
            g_q   <= g;

            if ((state == S_IDLE) && start) begin
                sel_q    <= bit_sel;
                meas_n   <= meas_cycles;
                idx      <= '0;
                overflow <= 1'b0;
            end

            if ((state == S_MEAS) && !period_end && !stop) begin
                have_rise <= c_have_rise;
                have_fall <= c_have_fall;
                multi     <= c_multi;
                rise_ts   <= c_rise_ts;
                fall_ts   <= c_fall_ts;
            end else begin
                have_rise <= 1'b0;
                have_fall <= 1'b0;
                multi     <= 1'b0;
                rise_ts   <= '0;
                fall_ts   <= '0;
            end

            if (period_end) begin
                idx <= idx + 8'd1;
            end

            if (period_end && !(result_valid && !result_ready)) begin
                result_valid <= 1'b1;
                result_idx   <= idx;
                result_rise  <= c_have_rise ? c_rise_ts : '0;
                result_fall  <= (c_have_rise && c_have_fall) ? c_fall_ts : '0;
                result_width <= (c_have_rise && c_have_fall) ? (c_fall_ts - c_rise_ts) : '0;
                result_flags <= {c_multi, c_have_rise & ~c_have_fall, ~c_have_rise};
            end else begin
                if (period_end) begin
                    overflow <= 1'b1;
                end
                if (result_valid && result_ready) begin
                    result_valid <= 1'b0;
                    result_rise  <= '0;
                    result_fall  <= '0;
                    result_width <= '0;
                    result_flags <= '0;
                    result_idx   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_pulse_monitor.sv
// tb/tb_gate_pulse_monitor.sv - self-checking bench for gate_pulse_monitor
module tb_gate_pulse_monitor;

    localparam int CW = 32;
    localparam int GB = 10;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] laser_cnt_in, laser_freq;
    logic [GB-1:0] gate_data_in;
    logic [SW-1:0] bit_sel;
    logic [7:0]    meas_cycles;
    logic          start, stop, busy, done, result_valid, result_ready, overflow;
    logic [CW-1:0] result_rise, result_fall, result_width;
    logic [2:0]    result_flags;
    logic [7:0]    result_idx;

    always #5 clk = ~clk;

    gate_pulse_monitor #(.CNT_WIDTH(CW), .GATE_BITS(GB), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .laser_cnt_in(laser_cnt_in), .laser_freq(laser_freq),
        .gate_data_in(gate_data_in), .bit_sel(bit_sel), .meas_cycles(meas_cycles),
        .start(start), .stop(stop), .busy(busy), .done(done),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_rise(result_rise), .result_fall(result_fall), .result_width(result_width),
        .result_flags(result_flags), .result_idx(result_idx), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] rise;
        logic [31:0] fall;
        logic [31:0] width;
        logic [2:0]  flags;
        logic [7:0]  idx;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   auto_chk, rand_ready, start_p, stop_p, prev_g;
    int   cur_sel, done_seen, ready_lo;
    bit   pat[0:255];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one clock cycle of inputs, score any accepted result, advance the counter.
    task automatic tick(input bit gb);
        logic [GB-1:0] v;
        res_t          r, e;
        v            = GB'($urandom);
        v[cur_sel]   = gb;
        gate_data_in = v;
        prev_g       = gb;
        start        = start_p;
        stop         = stop_p;
        if (rand_ready) begin
            result_ready = (ready_lo >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            ready_lo     = result_ready ? 0 : ready_lo + 1;
        end
        if (result_valid && result_ready) begin
            r.rise = result_rise; r.fall = result_fall; r.width = result_width;
            r.flags = result_flags; r.idx = result_idx;
            got_q.push_back(r);
            if (auto_chk) begin
                check("model_queue_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rise", r.rise, e.rise);
                    check("fall", r.fall, e.fall);
                    check("width", r.width, e.width);
                    check("flags", {29'd0, r.flags}, {29'd0, e.flags});
                    check("idx", {24'd0, r.idx}, {24'd0, e.idx});
                end
            end
        end
        @(posedge clk);
        #1;
        if (done) done_seen++;
        laser_cnt_in = (laser_cnt_in >= laser_freq) ? '0 : laser_cnt_in + 1;
    endtask

    // Reference: scan the period's samples for edges using the monitor's rules.
    function automatic res_t model(input int f, input bit p0, input int idx);
        res_t r;
        bit   prev, hr, hf, m;
        int   rt, ft;
        prev = p0; hr = 0; hf = 0; m = 0; rt = 0; ft = 0;
        for (int t = 0; t <= f; t++) begin
            if (pat[t] && !prev) begin
                if (!hr) begin hr = 1; rt = t; end
                else m = 1;
            end
            if (!pat[t] && prev && hr && !hf) begin hf = 1; ft = t; end
            prev = pat[t];
        end
        r.rise  = hr ? rt : 0;
        r.fall  = (hr && hf) ? ft : 0;
        r.width = (hr && hf) ? ft - rt : 0;
        r.flags = {m, hr && !hf, !hr};
        r.idx   = 8'(idx);
        return r;
    endfunction

    task automatic fill(input int mode, input int p, input int f);
        int s, l;
        for (int t = 0; t < 256; t++) pat[t] = 0;
        case (mode)
            0: for (int k = $urandom_range(0, 3); k > 0; k--) begin
                s = $urandom_range(0, f);
                l = $urandom_range(1, f / 3);
                for (int t = s; t <= f && t < s + l; t++) pat[t] = 1;
            end
            1: for (int t = 20; t <= 49; t++) pat[t] = 1;
            2: begin
                if (p == 1) for (int t = 90; t <= f; t++) pat[t] = 1;
                if (p == 2) for (int t = 0; t <= 30; t++) pat[t] = 1;
            end
            default: begin
                for (int t = 10; t <= 14; t++) pat[t] = 1;
                for (int t = 30; t <= 39; t++) pat[t] = 1;
            end
        endcase
    endtask

    task automatic arm_start(input int sel, input int mc, input int f);
        laser_freq = f; bit_sel = SW'(sel); meas_cycles = 8'(mc); cur_sel = sel;
        while (laser_cnt_in != 0) tick(0);
        repeat ($urandom_range(1, f / 2)) tick(0);
        start_p = 1; tick(0); start_p = 0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_meas(input int sel, input int mc, input int f, input int mode, input int nper);
        res_t e;
        arm_start(sel, mc, f);
        while (laser_cnt_in != 0) tick(0);
        done_seen = 0;
        for (int p = 0; p < nper; p++) begin
            fill(mode, p, f);
            e = model(f, prev_g, p);
            for (int t = 0; t <= f; t++) tick(pat[t]);
            if (auto_chk) exp_q.push_back(e);
            check("valid_after_hit", result_valid, 1);
            if (mc != 0 && p == mc - 1) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
            end else begin
                check("busy_in_meas", busy, 1);
            end
        end
        if (mc != 0) begin
            tick(0);
            check("done_count", done_seen, 1);
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        rst = 1; laser_cnt_in = 0; laser_freq = 99; gate_data_in = 0; bit_sel = 0;
        meas_cycles = 0; start = 0; stop = 0; result_ready = 1;
        start_p = 0; stop_p = 0; auto_chk = 1; rand_ready = 0; cur_sel = 0; ready_lo = 0;
        repeat (3) tick(0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", result_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rise", result_rise, 0);
        rst = 0;

        // Basic 20..49 pulse, two periods
        got_q.delete();
        run_meas(3, 2, 99, 1, 2);
        check("t1_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                check("t1_rise", got_q[i].rise, 20);
                check("t1_fall", got_q[i].fall, 50);
                check("t1_width", got_q[i].width, 30);
                check("t1_flags", {29'd0, got_q[i].flags}, 0);
                check("t1_idx", {24'd0, got_q[i].idx}, i);
            end
        end

        // No rise, open across boundary, then fall-only period
        got_q.delete();
        run_meas(7, 3, 99, 2, 3);
        check("t2_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("t2_p0_flags", {29'd0, got_q[0].flags}, 1);
            check("t2_p0_rise", got_q[0].rise, 0);
            check("t2_p1_flags", {29'd0, got_q[1].flags}, 2);
            check("t2_p1_rise", got_q[1].rise, 90);
            check("t2_p1_width", got_q[1].width, 0);
            check("t2_p2_flags", {29'd0, got_q[2].flags}, 1);
        end

        // Two pulses in one period
        got_q.delete();
        run_meas(0, 1, 99, 3, 1);
        check("t3_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            check("t3_rise", got_q[0].rise, 10);
            check("t3_fall", got_q[0].fall, 15);
            check("t3_width", got_q[0].width, 5);
            check("t3_flags", {29'd0, got_q[0].flags}, 4);
        end

        // Held result, overflow, then stop mid-period
        auto_chk = 0; got_q.delete(); result_ready = 0;
        run_meas(5, 0, 99, 1, 3);
        check("t4_overflow", overflow, 1);
        check("t4_held_idx", {24'd0, result_idx}, 0);
        result_ready = 1;
        fill(1, 3, 99);
        for (int t = 0; t <= 99; t++) tick(pat[t]);
        tick(0);
        check("t4_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t4_first_idx", {24'd0, got_q[0].idx}, 0);
            check("t4_second_idx", {24'd0, got_q[1].idx}, 3);
        end
        while (laser_cnt_in != 30) tick(0);
        stop_p = 1; tick(0); stop_p = 0;
        check("stop_busy", busy, 0);
        while (laser_cnt_in != 0) tick(0);
        tick(0);
        check("stop_no_result", result_valid, 0);
        check("stop_no_done", done_seen, 0);

        // Reset mid-MEAS
        arm_start(2, 0, 99);
        check("start_clears_overflow", overflow, 0);
        while (laser_cnt_in != 0) tick(0);
        while (laser_cnt_in != 40) tick(laser_cnt_in > 20);
        rst = 1; tick(0); rst = 0;
        check("rst2_busy", busy, 0);
        check("rst2_valid", result_valid, 0);
        check("rst2_idx", {24'd0, result_idx}, 0);
        check("rst2_flags", {29'd0, result_flags}, 0);
        check("rst2_width", result_width, 0);
        start_p = 1; tick(0); start_p = 0;
        while (laser_cnt_in != 97) tick(1);
        check("rst2_no_result", result_valid, 0);
        check("rst2_busy_armed", busy, 1);
        stop_p = 1; tick(0); stop_p = 0;

        // Randomized runs against the model
        auto_chk = 1; rand_ready = 1; exp_q.delete();
        for (int n = 0; n < 10; n++) begin
            int mc;
            mc = $urandom_range(1, 4);
            run_meas($urandom_range(0, GB - 1), mc, $urandom_range(20, 60), 0, mc);
            check("rand_overflow", overflow, 0);
        end
        repeat (8) tick(0);
        check("rand_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gate_pulse_monitor.md
Name: gate_pulse_monitor

Overview:
- Receive-side checker for the 10-bit gate bus produced by the frame gate pulse generator.
- Samples one selected gate bit against the shared laser period counter and timestamps its rising and falling edges within each laser period.
- Reports rise position, fall position, width and error flags for each period over a valid/ready result interface.
- Sits in the timing-generator IP beside the generator, for self-test and for delay/width calibration readback over AXI.

Parameters:
- CNT_WIDTH, 32, width of laser counter, period and timestamps.
- GATE_BITS, 10, width of gate_data_in.
- SEL_WIDTH, 4, width of bit_sel; must satisfy 2^SEL_WIDTH >= GATE_BITS.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- laser_cnt_in  in  CNT_WIDTH  free-running laser period counter, same signal the generator uses.
- laser_freq  in  CNT_WIDTH  period terminal value.
- gate_data_in  in  GATE_BITS  gate bus under test.
- bit_sel  in  SEL_WIDTH  gate bit to monitor; latched on start.
- meas_cycles  in  8  number of periods to measure; latched on start; 0 = continuous until stop.
- start  in  1  one-cycle pulse; arms a measurement.
- stop  in  1  one-cycle pulse; aborts the measurement.
- busy  out  1  high in ARM and MEAS.
- done  out  1  one-cycle pulse when meas_cycles periods have been measured.
- result_valid  out  1  a result is held.
- result_ready  in  1  consumer accepts the result.
- result_rise  out  CNT_WIDTH  laser_cnt_in value at the first rise.
- result_fall  out  CNT_WIDTH  laser_cnt_in value at the first fall after that rise.
- result_width  out  CNT_WIDTH  result_fall - result_rise.
- result_flags  out  3  [0] no_rise, [1] open (rise with no fall), [2] multi (more than one rise).
- result_idx  out  8  period index within the run, starting at 0.
- overflow  out  1  sticky: a result was dropped; cleared by start or rst.

Behaviour:
- Period boundary: hit = (laser_cnt_in >= laser_freq). The sample on the hit cycle belongs to the ending period.
- Edge detect on g = gate_data_in[bit_sel_latched], with registered g_q.
  - rise = g & ~g_q; fall = ~g & g_q.
  - g_q is cleared by rst only, not at boundaries. A gate high across a boundary therefore gives no rise in the new period.
- FSM states: IDLE, ARM, MEAS, DONE.
  - IDLE: start -> ARM; latch bit_sel and meas_cycles; clear overflow and the period index.
  - ARM: wait for hit -> MEAS. No result is produced for the partial period.
  - MEAS, per period:
    - Timestamp the first rise only.
    - Timestamp the first fall seen after that rise. A fall before any rise is ignored.
    - Any further rise in the same period sets multi.
  - MEAS at hit, build the result for the ending period:
    - No rise: rise=0, fall=0, width=0, no_rise=1.
    - Rise but no fall: fall=0, width=0, open=1.
    - Then clear the per-period capture and increment idx.
    - If meas_cycles != 0 and idx+1 == meas_cycles -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - stop in ARM or MEAS -> IDLE next cycle. No result for the partial period, no done pulse.
  - start while busy is ignored.
- Edge on the same cycle as hit: recorded in the ending period with timestamp laser_cnt_in.
- Width arithmetic: unsigned, CNT_WIDTH bits, no wrap handling. A fall always follows its rise inside one period.
- Result register (single entry):
  - Loaded one cycle after hit, so result_valid rises on hit+1.
  - Fields are stable while result_valid=1; cleared by result_valid & result_ready.
  - If a new result arrives while one is pending and not accepted that cycle, the new result is dropped and overflow sets.
  - Accept and load in the same cycle: the new result loads, no overflow.
  - A pending result survives stop and is still delivered.
- Latency: timestamps are raw laser_cnt_in at the cycle the edge is visible at this block's input, with no compensation. Generator output register offsets are applied by software.
- Reset: every output is 0 and the FSM is in IDLE.

Test Plan:
- laser_freq=99, bit_sel=3, meas_cycles=2, bit3 high for cnt 20..49 each period, ready tied 1 -> two results: rise=20, fall=50, width=30, flags=0, idx=0 then 1; done pulses once; busy drops with it.
- Gate held low for a whole period -> flags=3'b001, rise=fall=width=0. Gate rising at cnt 90 and held past the boundary -> flags=3'b010, width=0; following period reports no_rise.
- Two pulses, cnt 10..14 and 30..39 -> rise=10, fall=15, width=5, flags=3'b100.
- result_ready=0 for three periods with meas_cycles=0 -> first result (idx=0) is held, overflow=1. Raise ready -> idx=0 accepted; next accepted result has idx=3.
- stop mid-period, then rst asserted mid-MEAS -> after stop: no partial result, no done, busy=0. After rst: all outputs 0; a start without an intervening hit produces no result.
